// File: rtl/corr_z_range_reduce.sv
// Range reduction of the CORDIC z input: either halve until |z| < LIMIT_Q (scale)
// or step by 2*pi until z lies in (-pi, pi] (wrap), one iteration per cycle.
module corr_z_range_reduce #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 16,
   parameter int LIMIT_Q  = 131072,
   parameter int PI_Q     = 205887,
   parameter int TWO_PI_Q = 411775,
   parameter int CNT_W    = 16,
   parameter int MAX_ITER = 8191
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] z_in,
   input  logic             mode_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z_out,
   output logic [CNT_W-1:0] count_out,
   output logic             err
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic signed [WIDTH-1:0] LIM_S     = WIDTH'(LIMIT_Q);
   localparam logic signed [WIDTH-1:0] NEG_LIM_S = -LIM_S;
   localparam logic signed [WIDTH-1:0] PI_S      = WIDTH'(PI_Q);
   localparam logic signed [WIDTH-1:0] NEG_PI_S  = -PI_S;
   localparam logic signed [WIDTH-1:0] TWO_PI_S  = WIDTH'(TWO_PI_Q);
   localparam logic        [CNT_W-1:0] MAX_C     = CNT_W'(MAX_ITER);

   // Constants are pre-scaled, so FRAC only has to be a sane value.
   if (FRAC >= WIDTH) begin : g_frac_chk
      $error("FRAC must be smaller than WIDTH");
   end

   state_t                   state_q, state_d;
   logic signed [WIDTH-1:0]  z_q, z_d;
   logic                     mode_q, mode_d;
   logic        [CNT_W-1:0]  cnt_q, cnt_d;
   logic        [WIDTH-1:0]  z_out_q, z_out_d;
   logic        [CNT_W-1:0]  cnt_out_q, cnt_out_d;
   logic                     err_q, err_d;
   logic                     valid_q, valid_d;
   logic                     in_range_s;

   assign in_range_s = mode_q ? ((z_q > NEG_PI_S) && (z_q <= PI_S))
                              : ((z_q > NEG_LIM_S) && (z_q < LIM_S));

   always_comb begin
      state_d   = state_q;
      z_d       = z_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      z_out_d   = z_out_q;
      cnt_out_d = cnt_out_q;
      err_d     = err_q;
      valid_d   = valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               z_d     = $signed(z_in);
               mode_d  = mode_in;
               cnt_d   = {CNT_W{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (in_range_s || (cnt_q == MAX_C)) begin
               z_out_d   = z_q;
               cnt_out_d = cnt_q;
               err_d     = ~in_range_s;
               valid_d   = 1'b1;
               state_d   = DONE;
            end else begin
               if (mode_q) begin
                  z_d = (z_q > PI_S) ? (z_q - TWO_PI_S) : (z_q + TWO_PI_S);
               end else begin
                  z_d = z_q >>> 1;
               end
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         z_q       <= {WIDTH{1'b0}};
         mode_q    <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         z_out_q   <= {WIDTH{1'b0}};
         cnt_out_q <= {CNT_W{1'b0}};
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         z_q       <= z_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         z_out_q   <= z_out_d;
         cnt_out_q <= cnt_out_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = valid_q;
   assign z_out     = z_out_q;
   assign count_out = cnt_out_q;
   assign err       = err_q;

endmodule

// File: tb/tb_corr_z_range_reduce.sv
// Scoreboard bench: two instances (default cap and MAX_ITER=4) share stimulus;
// each has its own expected queue filled at acceptance and drained by a monitor.
module tb_corr_z_range_reduce;

   localparam longint LIM = 131072;
   localparam longint PI  = 205887;
   localparam longint TWO = 411775;

   logic        clk = 1'b0;
   logic        rst, in_valid, mode_in, out_ready;
   logic [31:0] z_in;
   logic        rdy_a, vo_a, err_a, rdy_b, vo_b, err_b;
   logic [31:0] zo_a, zo_b;
   logic [15:0] co_a, co_b;

   always #5 clk = ~clk;

   corr_z_range_reduce u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .z_in(z_in),
      .mode_in(mode_in), .out_valid(vo_a), .out_ready(out_ready), .z_out(zo_a),
      .count_out(co_a), .err(err_a));

   corr_z_range_reduce #(.MAX_ITER(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .z_in(z_in),
      .mode_in(mode_in), .out_valid(vo_b), .out_ready(out_ready), .z_out(zo_b),
      .count_out(co_b), .err(err_b));

   logic        rdy[2], vo[2], er[2];
   logic [31:0] zo[2];
   logic [15:0] co[2];
   assign rdy[0] = rdy_a;  assign rdy[1] = rdy_b;
   assign vo[0]  = vo_a;   assign vo[1]  = vo_b;
   assign er[0]  = err_a;  assign er[1]  = err_b;
   assign zo[0]  = zo_a;   assign zo[1]  = zo_b;
   assign co[0]  = co_a;   assign co[1]  = co_b;

   typedef struct {
      logic [31:0] z;
      int          cnt;
      bit          err;
      longint      acc;
   } exp_t;

   exp_t   q[2][$];
   exp_t   cur[2];
   int     checks = 0;
   int     fails  = 0;
   longint cyc    = 0;
   int     hs[2]   = '{0, 0};
   int     pops[2] = '{0, 0};
   int     maxit[2] = '{8191, 4};
   int     bnd[8] = '{131072, -131072, 131071, -131071, 205887, -205887, 205888, -205888};

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Reference: apply the reduction rules directly on plain integers.
   function automatic exp_t model(input logic [31:0] zin, input bit m, input int mx);
      exp_t   e;
      longint z;
      int     n;
      bit     ok;
      z = longint'($signed(zin));
      n = 0;
      while (1) begin
         ok = m ? (z > -PI && z <= PI) : (z > -LIM && z < LIM);
         if (ok) begin e.err = 1'b0; break; end
         if (n == mx) begin e.err = 1'b1; break; end
         if (m) z = (z > PI) ? z - TWO : z + TWO;
         else   z = (z < 0 && z % 2 != 0) ? z / 2 - 1 : z / 2;
         n++;
      end
      e.z   = z[31:0];
      e.cnt = n;
      e.acc = 0;
      return e;
   endfunction

   // Acceptance tracking: push the expected result on every accepting edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            q[i].delete();
            hs[i] = pops[i];
         end else begin
            if (in_valid && rdy[i]) begin
               exp_t e;
               e = model(z_in, mode_in, maxit[i]);
               e.acc = cyc;
               q[i].push_back(e);
            end
            if (vo[i] && out_ready) hs[i]++;
         end
      end
      cyc++;
   end

   // Monitor: compare each presented result once, then check it holds while stalled.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (vo[i] === 1'b1) begin
            if (pops[i] == hs[i]) begin
               pops[i]++;
               if (q[i].size() == 0) begin
                  chk($sformatf("unexpected_out[%0d]", i), vo[i], 0);
                  cur[i].z = zo[i]; cur[i].cnt = int'(co[i]); cur[i].err = er[i];
               end else begin
                  cur[i] = q[i].pop_front();
                  chk($sformatf("z_out[%0d]", i), zo[i], cur[i].z);
                  chk($sformatf("count_out[%0d]", i), co[i], cur[i].cnt);
                  chk($sformatf("err[%0d]", i), er[i], cur[i].err);
                  chk($sformatf("latency[%0d]", i), cyc - cur[i].acc - 1, cur[i].cnt + 1);
               end
            end else begin
               chk($sformatf("hold_z[%0d]", i), zo[i], cur[i].z);
               chk($sformatf("hold_cnt[%0d]", i), co[i], cur[i].cnt);
               chk($sformatf("hold_err[%0d]", i), er[i], cur[i].err);
            end
            chk($sformatf("busy_in_ready[%0d]", i), rdy[i], 0);
         end
      end
   end

   task automatic check_idle(input string nm);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_out_valid[%0d]", nm, i), vo[i], 0);
         chk($sformatf("%s_in_ready[%0d]", nm, i), rdy[i], 1);
         chk($sformatf("%s_z_out[%0d]", nm, i), zo[i], 0);
         chk($sformatf("%s_count[%0d]", nm, i), co[i], 0);
         chk($sformatf("%s_err[%0d]", nm, i), er[i], 0);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (!(rdy[0] && rdy[1] && q[0].size() == 0 && q[1].size() == 0) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) begin
         checks++; fails++;
         $display("FAIL drain_timeout actual=%0d cycles required=<20000", t);
      end
   endtask

   task automatic send(input logic [31:0] z, input logic m);
      int t = 0;
      while (!(rdy[0] && rdy[1]) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) begin
         checks++; fails++;
         $display("FAIL send_timeout actual=%0d cycles required=<20000", t);
      end
      in_valid = 1'b1; z_in = z; mode_in = m;
      @(negedge clk);
      in_valid = 1'b0; z_in = $urandom; mode_in = 1'($urandom % 2);
   endtask

   initial begin
      int t;
      int sel;
      rst = 1'b1; in_valid = 1'b0; z_in = 32'd0; mode_in = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle("reset");

      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         in_valid  = ($urandom % 3 == 0);
         mode_in   = 1'($urandom % 2);
         out_ready = ($urandom % 4 != 0);
         sel = int'($urandom % 4);
         if (mode_in && sel == 0) sel = 3;
         case (sel)
            0:       z_in = $urandom;
            1:       z_in = 32'($urandom_range(0, 1048576)) - 32'd524288;
            2:       z_in = 32'(bnd[$urandom % 8]);
            default: z_in = 32'($urandom_range(0, 8388608)) - 32'd4194304;
         endcase
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();

      send(32'h0005_0000, 1'b0); drain();
      send(32'h0002_0000, 1'b0); drain();
      send(32'h8000_0000, 1'b0); drain();
      send(32'hFFFE_8000, 1'b0); drain();
      send(32'd458752, 1'b1);    drain();
      send(32'd205887, 1'b1);    drain();
      send(-32'sd205887, 1'b1);  drain();
      send(32'h7FFF_FFFF, 1'b1); drain();

      out_ready = 1'b0;
      send(32'h0005_0000, 1'b0);
      t = 0;
      while (vo[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
         checks++; fails++;
         $display("FAIL bp_wait_valid actual=%0d cycles required=<100", t);
      end
      repeat (10) begin
         @(negedge clk);
         in_valid = 1'($urandom % 2); z_in = $urandom; mode_in = 1'($urandom % 2);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_out_valid_low", vo[0], 0);
      chk("bp_in_ready_high", rdy[0], 1);
      drain();

      send(32'h7FFF_FFFF, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("mid_run_reset");
      repeat (30) @(negedge clk);
      send(32'h0005_0000, 1'b0); drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
